// File: rtl/mips_issue_arbiter_if.sv
// Requester, datapath and response signals of the MIPS issue arbiter.
// slave is the arbiter side; master is the requester/datapath side.
`timescale 1ns/1ps
interface mips_issue_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_instr;
   logic [19:0] req0_oreg;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_instr;
   logic [19:0] req1_oreg;
   logic        mips_in_valid;
   logic [31:0] mips_instruction;
   logic [19:0] mips_output_reg;
   logic        mips_out_valid;
   logic        mips_instruction_fail;
   logic        rsp_valid;
   logic        rsp_id;
   logic        rsp_fail;
   logic [2:0]  inflight_cnt;
   logic [7:0]  fail_cnt;
   logic        err;

   modport slave (
      input  req0_valid, req0_instr, req0_oreg,
      input  req1_valid, req1_instr, req1_oreg,
      input  mips_out_valid, mips_instruction_fail,
      output req0_ready, req1_ready,
      output mips_in_valid, mips_instruction, mips_output_reg,
      output rsp_valid, rsp_id, rsp_fail,
      output inflight_cnt, fail_cnt, err
   );

   modport master (
      output req0_valid, req0_instr, req0_oreg,
      output req1_valid, req1_instr, req1_oreg,
      output mips_out_valid, mips_instruction_fail,
      input  req0_ready, req1_ready,
      input  mips_in_valid, mips_instruction, mips_output_reg,
      input  rsp_valid, rsp_id, rsp_fail,
      input  inflight_cnt, fail_cnt, err
   );
endinterface

// File: rtl/mips_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a MIPS datapath; tracks the owner
// of each in-flight instruction in a tag FIFO and routes results back to it.
`timescale 1ns/1ps
module mips_issue_arbiter #(
   parameter int unsigned MAX_INFLIGHT = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   mips_issue_arbiter_if.slave bus
);
   localparam int unsigned PTR_W    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam logic [2:0]  CNT_MAX  = 3'(MAX_INFLIGHT);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MAX_INFLIGHT - 1);

   logic                    last_grant_q, last_grant_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [MAX_INFLIGHT-1:0] tag_q, tag_d;
   logic                    in_valid_q, in_valid_d;
   logic [31:0]             instr_q, instr_d;
   logic [19:0]             oreg_q, oreg_d;
   logic [7:0]              fail_cnt_q, fail_cnt_d;
   logic                    err_q, err_d;

   logic full, empty, prio0, prio1, ready0, ready1, hs0, hs1, push, pop;

   always_comb begin
      full  = (cnt_q == CNT_MAX);
      empty = (cnt_q == '0);
      // Each port's grant only looks at the other port's offer, so ready never
      // depends on its own valid; the two grants are exclusive whenever both offer.
      prio0  = !bus.req1_valid || last_grant_q;
      prio1  = !bus.req0_valid || !last_grant_q;
      ready0 = prio0 && !full;
      ready1 = prio1 && !full;
      hs0    = bus.req0_valid && ready0;
      hs1    = bus.req1_valid && ready1;
      push   = hs0 || hs1;
      pop    = bus.mips_out_valid && !empty;

      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      tag_d        = tag_q;
      in_valid_d   = push;
      instr_d      = '0;
      oreg_d       = '0;
      fail_cnt_d   = fail_cnt_q;
      err_d        = err_q || (bus.mips_out_valid && empty);

      if (hs0) begin
         instr_d = bus.req0_instr;
         oreg_d  = bus.req0_oreg;
      end else if (hs1) begin
         instr_d = bus.req1_instr;
         oreg_d  = bus.req1_oreg;
      end

      if (push) begin
         last_grant_d    = hs1;
         tag_d[wr_ptr_q] = hs1;
         wr_ptr_d        = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end

      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
         if (bus.mips_instruction_fail && fail_cnt_q != '1)
            fail_cnt_d = fail_cnt_q + 8'd1;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tag_q        <= '0;
         in_valid_q   <= 1'b0;
         instr_q      <= '0;
         oreg_q       <= '0;
         fail_cnt_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tag_q        <= tag_d;
         in_valid_q   <= in_valid_d;
         instr_q      <= instr_d;
         oreg_q       <= oreg_d;
         fail_cnt_q   <= fail_cnt_d;
         err_q        <= err_d;
      end
   end

   assign bus.req0_ready       = ready0;
   assign bus.req1_ready       = ready1;
   assign bus.mips_in_valid    = in_valid_q;
   assign bus.mips_instruction = instr_q;
   assign bus.mips_output_reg  = oreg_q;
   assign bus.rsp_valid        = pop;
   assign bus.rsp_id           = tag_q[rd_ptr_q];
   assign bus.rsp_fail         = bus.mips_instruction_fail;
   assign bus.inflight_cnt     = cnt_q;
   assign bus.fail_cnt         = fail_cnt_q;
   assign bus.err              = err_q;
endmodule

// File: doc/mips_issue_arbiter.md
MIPS_ISSUE_ARBITER -- requirements
Module: mips_issue_arbiter

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 5: maximum number of accepted-but-unanswered instructions; legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester N offers an instruction.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 bit each: requester N's offer is accepted this cycle.
REQ-006 SHALL have ports req0_instr/req1_instr, input, 32 bits each: MIPS instruction word.
REQ-007 SHALL have ports req0_oreg/req1_oreg, input, 20 bits each: four 5-bit output-register selects.
REQ-008 SHALL have port mips_in_valid, output, 1 bit: issue strobe to the MIPS datapath.
REQ-009 SHALL have port mips_instruction, output, 32 bits: issued instruction.
REQ-010 SHALL have port mips_output_reg, output, 20 bits: issued output-register selects.
REQ-011 SHALL have port mips_out_valid, input, 1 bit: datapath result strobe.
REQ-012 SHALL have port mips_instruction_fail, input, 1 bit: datapath failure flag.
REQ-013 SHALL have port rsp_valid, output, 1 bit: a result belongs to requester rsp_id.
REQ-014 SHALL have port rsp_id, output, 1 bit: owning requester.
REQ-015 SHALL have port rsp_fail, output, 1 bit: the owning instruction failed.
REQ-016 SHALL have port inflight_cnt, output, 3 bits: current in-flight count.
REQ-017 SHALL have port fail_cnt, output, 8 bits: failures counted since reset.
REQ-018 SHALL have port err, output, 1 bit: sticky protocol error.

Function
REQ-019 SHALL accept (handshake) requester N when reqN_valid and reqN_ready are both 1 in the same cycle; at most one handshake per cycle.
REQ-020 SHALL compute reqN_ready combinationally: grant to N AND (inflight_cnt < MAX_INFLIGHT); ready SHALL NOT depend on reqN_valid of the same port.
REQ-021 SHALL grant the sole valid requester; with both valid, SHALL grant the requester not equal to last_grant; with none valid, SHALL grant nobody.
REQ-022 SHALL update last_grant only on a handshake, set to the accepted id.
REQ-023 SHALL register the accepted instr/oreg onto mips_instruction/mips_output_reg and SHALL pulse mips_in_valid one cycle after the handshake (latency 1).
REQ-024 SHALL drive mips_instruction and mips_output_reg to 0 and mips_in_valid to 0 in cycles without a preceding handshake.
REQ-025 SHALL push the accepted id into a tag FIFO of depth MAX_INFLIGHT on each handshake.
REQ-026 SHALL pop the FIFO head on mips_out_valid when the FIFO is non-empty.
REQ-027 SHALL combinationally drive rsp_valid=mips_out_valid, rsp_id=head and rsp_fail=mips_instruction_fail in that cycle.
REQ-028 SHALL support a simultaneous push and pop when non-empty, preserving order; FIFO pointers SHALL wrap modulo MAX_INFLIGHT.
REQ-029 SHALL increment inflight_cnt on a handshake, decrement it on a valid pop, and hold it on both or neither.
REQ-030 SHALL never let inflight_cnt exceed MAX_INFLIGHT; when full, both ready outputs SHALL be 0.
REQ-031 SHALL, on mips_out_valid with the FIFO empty: set err=1; keep rsp_valid=0; leave the FIFO and inflight_cnt unchanged; err SHALL clear only on reset.
REQ-032 SHALL increment fail_cnt on each valid pop with mips_instruction_fail=1, saturating at 255.

Reset
REQ-033 SHALL, on rst_n low, immediately clear all registered outputs (mips_in_valid, mips_instruction, mips_output_reg, inflight_cnt, fail_cnt, err) to 0, empty the FIFO and set last_grant=1, so that requester 0 wins the first contention.
REQ-034 SHALL discard all in-flight tags on reset mid-operation; the first mips_out_valid after reset SHALL raise err.

Verification
REQ-035 Both requesters valid continuously, datapath answering 4 cycles after mips_in_valid -> grants alternate 0,1,0,1; rsp_id sequence matches issue order.
REQ-036 Only req1 valid for 10 cycles, no responses, MAX_INFLIGHT=5 -> exactly 5 handshakes, then req1_ready=0 and inflight_cnt=5.
REQ-037 inflight_cnt=5, then response and req0_valid in the same cycle -> ready=0 that cycle; next cycle handshake occurs and inflight_cnt returns to 5.
REQ-038 Handshake with instr=32'h0232_4020 at cycle t -> mips_in_valid=1 and mips_instruction=32'h0232_4020 at t+1 only.
REQ-039 mips_out_valid with the FIFO empty -> err=1 stays set; rsp_valid=0; inflight_cnt=0.
REQ-040 300 responses with fail=1 -> fail_cnt=255; reset asserted mid-stream -> all outputs 0 asynchronously.
